// File: rtl/dram_pkg.sv
// Shared geometry, address types and command decode encoding for the DRAM model.
package dram_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_SIZE = 11;
  localparam int unsigned ROW_BITS  = 11;
  localparam int unsigned COL_BITS  = 10;
  localparam int unsigned WA_BITS   = ROW_BITS + COL_BITS;
  localparam int unsigned DEPTH     = 2 ** WA_BITS;
  localparam int unsigned LANES     = WORD_SIZE / 8;

  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [COL_BITS-1:0] col_t;
  typedef logic [WA_BITS-1:0]  word_addr_t;

  // One decoded command per clock edge.
  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_READ,
    CMD_WRITE
  } cmd_e;

  function automatic word_addr_t make_addr(row_t row, col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/dram_byte_lane.sv
// One byte lane of the data path: lane write strobe and next value of the read byte.
module dram_byte_lane
  import dram_pkg::*;
(
  input  logic       wr_i,     // column write access this edge
  input  logic       rd_i,     // column read access this edge
  input  logic       we_n_i,   // lane write enable, active-low
  input  logic [7:0] mem_i,    // stored byte at the accessed address
  input  logic [7:0] q_i,      // current registered read byte
  output logic       wr_o,     // store D byte into this lane's array
  output logic [7:0] q_d_o     // next read byte
);

  // Lane stores only when its own enable is low; the read byte holds unless a read happens.
  always_comb begin
    wr_o  = wr_i & ~we_n_i;
    q_d_o = rd_i ? mem_i : q_i;
  end

endmodule

// File: rtl/dram.sv
// Single-bank DRAM model: RAS opens a row, CAS-low cycles access columns, byte-lane writes.
module dram
  import dram_pkg::*;
(
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 CSn,
  input  logic                 RASn,
  input  logic                 CASn,
  input  logic [LANES-1:0]     WEn,
  input  logic [ADDR_SIZE-1:0] A,
  input  logic [WORD_SIZE-1:0] D,
  output logic [WORD_SIZE-1:0] Q
);

  // Byte arrays stay at this level so benches can preload them by name.
  logic [7:0] Memory_byte0 [0:DEPTH-1];
  logic [7:0] Memory_byte1 [0:DEPTH-1];
  logic [7:0] Memory_byte2 [0:DEPTH-1];
  logic [7:0] Memory_byte3 [0:DEPTH-1];

  row_t                 row_q, row_d;
  logic                 open_q, open_d;
  logic [WORD_SIZE-1:0] q_q, q_d;
  cmd_e                 cmd;
  word_addr_t           addr;
  logic                 acc_wr, acc_rd;
  logic [LANES-1:0]     lane_wr;
  logic [7:0]           mem_rd [LANES];

  assign addr = make_addr(row_q, col_t'(A[COL_BITS-1:0]));

  assign mem_rd[0] = Memory_byte0[addr];
  assign mem_rd[1] = Memory_byte1[addr];
  assign mem_rd[2] = Memory_byte2[addr];
  assign mem_rd[3] = Memory_byte3[addr];

  // Command decode; precharge wins over everything and ignores chip select.
  always_comb begin
    cmd = CMD_NOP;
    if (RASn)
      cmd = CMD_PRE;
    else if (!CSn && !open_q)
      cmd = CMD_ACT;
    else if (!CSn && open_q && !CASn)
      cmd = (WEn == '1) ? CMD_READ : CMD_WRITE;
  end

  // Row register and open flag next state.
  always_comb begin
    open_d = open_q;
    row_d  = row_q;
    case (cmd)
      CMD_ACT: begin
        open_d = 1'b1;
        row_d  = row_t'(A[ROW_BITS-1:0]);
      end
      CMD_PRE: open_d = 1'b0;
      default: ;
    endcase
  end

  assign acc_wr = RST & (cmd == CMD_WRITE);
  assign acc_rd = RST & (cmd == CMD_READ);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dram_byte_lane u_lane (
      .wr_i   (acc_wr),
      .rd_i   (acc_rd),
      .we_n_i (WEn[i]),
      .mem_i  (mem_rd[i]),
      .q_i    (q_q[8*i +: 8]),
      .wr_o   (lane_wr[i]),
      .q_d_o  (q_d[8*i +: 8])
    );
  end

  // Control and read-data registers with synchronous active-low reset.
  always_ff @(posedge CK) begin
    if (!RST) begin
      q_q    <= '0;
      open_q <= 1'b0;
      row_q  <= '0;
    end else begin
      q_q    <= q_d;
      open_q <= open_d;
      row_q  <= row_d;
    end
  end

  // Array writes per lane; arrays are never reset.
  always_ff @(posedge CK) begin
    if (lane_wr[0]) Memory_byte0[addr] <= D[7:0];
    if (lane_wr[1]) Memory_byte1[addr] <= D[15:8];
    if (lane_wr[2]) Memory_byte2[addr] <= D[23:16];
    if (lane_wr[3]) Memory_byte3[addr] <= D[31:24];
  end

  assign Q = q_q;

endmodule

// File: tb/tb_dram.sv
// Directed self-checking bench for the DRAM model.
module tb_dram;

  logic        CK = 1'b0;
  logic        RST;
  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  int n_cmp = 0;
  int n_err = 0;

  dram dut (
    .CK   (CK),
    .RST  (RST),
    .CSn  (CSn),
    .RASn (RASn),
    .CASn (CASn),
    .WEn  (WEn),
    .A    (A),
    .D    (D),
    .Q    (Q)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    CSn = 1'b0; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF;
  endtask

  task automatic wr(input logic [10:0] row, input logic [9:0] col,
                    input logic [31:0] data, input logic [3:0] wen);
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; WEn = 4'hF; A = row;
    tick();
    A = {1'b0, col}; D = data; WEn = wen; CASn = 1'b0;
    tick();
    idle();
    tick();
  endtask

  task automatic rd(input string tag, input logic [10:0] row, input logic [9:0] col,
                    input logic [31:0] exp);
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; WEn = 4'hF; A = row;
    tick();
    A = {1'b0, col}; CASn = 1'b0;
    tick();
    chk(tag, Q, exp);
    idle();
    tick();
  endtask

  initial begin
    logic [20:0] pidx;
    RST = 1'b0; CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = 4'hF; A = '0; D = '0;

    // Preload word {row 7, col 3} = 32'h12345678 directly into the arrays.
    pidx = {11'd7, 10'd3};
    dut.Memory_byte0[pidx] = 8'h78;
    dut.Memory_byte1[pidx] = 8'h56;
    dut.Memory_byte2[pidx] = 8'h34;
    dut.Memory_byte3[pidx] = 8'h12;

    // Reset for two cycles.
    tick();
    tick();
    chk("reset_q", Q, 32'h0);
    chk("reset_row_closed", {31'h0, dut.open_q}, 32'h0);
    RST = 1'b1;
    idle();
    tick();

    chk("preload_read", 32'h0, 32'h0) ;
    rd("preload_read_7_3", 11'd7, 10'd3, 32'h12345678);

    // Neighbours for the overwrite check.
    wr(11'd5, 10'd9,  32'h0000_0099, 4'h0);
    wr(11'd5, 10'd12, 32'h0000_00CC, 4'h0);

    // Write burst: activate row 5, then cols 10 and 11 while CASn stays low.
    CSn = 1'b0; RASn = 1'b0; A = 11'd5;
    tick();
    A = 11'd10; WEn = 4'h0; D = 32'd10; CASn = 1'b0;
    tick();
    A = 11'd11; D = 32'd11;
    tick();
    idle();
    tick();
    chk("precharge_closes", {31'h0, dut.open_q}, 32'h0);

    // Read burst: Q follows one cycle after each access edge.
    RASn = 1'b0; A = 11'd5;
    tick();
    A = 11'd10; CASn = 1'b0;
    tick();
    chk("burst_rd_10", Q, 32'd10);
    A = 11'd11;
    tick();
    chk("burst_rd_11", Q, 32'd11);
    idle();
    tick();
    chk("q_holds_after_read", Q, 32'd11);

    // Overwrite burst with 13/14, then read it and neighbours.
    RASn = 1'b0; A = 11'd5;
    tick();
    A = 11'd10; WEn = 4'h0; D = 32'd13; CASn = 1'b0;
    tick();
    chk("q_holds_during_write", Q, 32'd11);
    A = 11'd11; D = 32'd14;
    tick();
    idle();
    tick();
    RASn = 1'b0; A = 11'd5;
    tick();
    A = 11'd9; CASn = 1'b0;
    tick();
    chk("ovw_rd_9", Q, 32'h99);
    A = 11'd10;
    tick();
    chk("ovw_rd_10", Q, 32'd13);
    A = 11'd11;
    tick();
    chk("ovw_rd_11", Q, 32'd14);
    A = 11'd12;
    tick();
    chk("ovw_rd_12", Q, 32'hCC);
    idle();
    tick();

    // Byte write: only lane 1 updated.
    wr(11'd3, 10'd0, 32'h11223344, 4'h0);
    wr(11'd3, 10'd0, 32'hAABBCCDD, 4'b1101);
    rd("byte_write", 11'd3, 10'd0, 32'h1122CC44);

    // Guard setup.
    wr(11'd3, 10'd1, 32'h01010101, 4'h0);
    wr(11'd3, 10'd3, 32'h33333333, 4'h0);
    rd("guard_setup", 11'd3, 10'd1, 32'h01010101);

    // CSn=1 with RAS low: no activation, no access.
    CSn = 1'b1; RASn = 1'b0; CASn = 1'b1; A = 11'd3;
    tick();
    chk("csn_no_activate", {31'h0, dut.open_q}, 32'h0);
    CASn = 1'b0; WEn = 4'h0; D = 32'hFFFFFFFF; A = 11'd1;
    tick();
    chk("csn_q_holds", Q, 32'h01010101);
    // CAS low with RAS high: ignored.
    CSn = 1'b0; RASn = 1'b1;
    tick();
    idle();
    tick();
    rd("guard_no_write", 11'd3, 10'd1, 32'h01010101);

    // CSn=1 with row open: access ignored; precharge still honoured.
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; A = 11'd3;
    tick();
    CSn = 1'b1; CASn = 1'b0; WEn = 4'h0; D = 32'hFFFFFFFF; A = 11'd1;
    tick();
    CASn = 1'b1; WEn = 4'hF; RASn = 1'b1;
    tick();
    chk("csn_precharge", {31'h0, dut.open_q}, 32'h0);
    rd("csn_open_no_write", 11'd3, 10'd1, 32'h01010101);

    // CAS low on the activation edge: activation only.
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b0; WEn = 4'h0; D = 32'hFFFFFFFF; A = 11'd3;
    tick();
    chk("act_edge_opens", {31'h0, dut.open_q}, 32'h1);
    idle();
    tick();
    rd("act_edge_no_write", 11'd3, 10'd3, 32'h33333333);

    // Reset mid-burst.
    CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; WEn = 4'hF; A = 11'd3;
    tick();
    A = 11'd0; CASn = 1'b0;
    tick();
    chk("pre_reset_read", Q, 32'h1122CC44);
    RST = 1'b0; A = 11'd1; WEn = 4'h0; D = 32'hFFFFFFFF;
    tick();
    chk("midburst_reset_q", Q, 32'h0);
    chk("midburst_reset_closed", {31'h0, dut.open_q}, 32'h0);
    RST = 1'b1;
    idle();
    tick();
    rd("midburst_no_write", 11'd3, 10'd1, 32'h01010101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
